// File: rtl/cfifo_n_if.sv
// Handshake bundle for cfifo_n: upstream drive/free, downstream driveNext/freeNext,
// per-stage fire strobes and occupancy/error status.
interface cfifo_n_if #(
  parameter int DEPTH = 4
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             i_drive;
  logic             o_free;
  logic             o_driveNext;
  logic             i_freeNext;
  logic [DEPTH-1:0] o_fire;
  logic [CNT_W-1:0] o_count;
  logic             o_err;

  modport master (
    output i_drive, i_freeNext,
    input  o_free, o_driveNext, o_fire, o_count, o_err
  );

  modport slave (
    input  i_drive, i_freeNext,
    output o_free, o_driveNext, o_fire, o_count, o_err
  );
endinterface

// File: rtl/cfifo_n.sv
// DEPTH-stage clocked click-FIFO controller with programmable output delay, occupancy and
// sticky protocol-error flag. Define CFIFO_FLOWTHRU_EN to let a leaving stage refill in the same cycle.
module cfifo_n #(
  parameter int DEPTH     = 4,
  parameter int OUT_DELAY = 2
) (
  input  logic      clk,
  input  logic      rst,
  cfifo_n_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DLY_W = (OUT_DELAY > 1) ? $clog2(OUT_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(OUT_DELAY - 1);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DELAY     = 2'd1,
    ST_WAIT_FREE = 2'd2
  } state_t;

  // With a one-cycle delay the last-stage fire offers the token immediately.
  localparam state_t LOAD_ST    = (OUT_DELAY == 1) ? ST_WAIT_FREE : ST_DELAY;
  localparam logic   LOAD_PULSE = (OUT_DELAY == 1);

  logic [DEPTH-1:0] full_r;
  logic [DEPTH-1:0] full_n;
  logic [DEPTH-1:0] prev_s;
  logic [DEPTH:0]   move_s;
  logic             consume_s;
  logic             drive_err_s;
  logic             free_err_s;
  state_t           state_r;
  state_t           state_n;
  logic [DLY_W-1:0] cnt_r;
  logic [DLY_W-1:0] cnt_n;
  logic             drive_next_n;
  logic             drive_next_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_n;
  logic             err_r;
  logic             free_r;

  // prev_s[k] is the token source feeding stage k: upstream for stage 0, else the stage behind.
  assign prev_s      = (full_r << 1'b1) | DEPTH'(bus.i_drive);
  assign consume_s   = bus.i_freeNext & (state_r == ST_WAIT_FREE);
  assign drive_err_s = bus.i_drive & ~move_s[0];
  assign free_err_s  = bus.i_freeNext & ~consume_s;

  // move_s[k] fires stage k; move_s[DEPTH] is the downstream consume, so move_s[k+1] means stage k leaves.
  always_comb begin : stage_move
    logic [DEPTH:0] mv_v;
    mv_v        = '0;
    mv_v[DEPTH] = consume_s;
    for (int k = DEPTH - 1; k >= 0; k--) begin
`ifdef CFIFO_FLOWTHRU_EN
      mv_v[k] = prev_s[k] & (~full_r[k] | mv_v[k+1]);
`else
      mv_v[k] = prev_s[k] & ~full_r[k];
`endif
    end
    move_s = mv_v;
  end

  // Next occupancy: a stage empties when its token leaves and fills when a token fires in.
  always_comb begin
    full_n  = (full_r & ~move_s[DEPTH:1]) | move_s[DEPTH-1:0];
    count_n = count_r + CNT_W'(move_s[0]) - CNT_W'(consume_s);
  end

  // Output FSM next state: delay the offer after a last-stage fire, then hold it until consumed.
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    drive_next_n = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (move_s[DEPTH-1]) begin
          state_n      = LOAD_ST;
          cnt_n        = DLY_LOAD;
          drive_next_n = LOAD_PULSE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DELAY: begin
        cnt_n = cnt_r - DLY_ONE;
        if (cnt_r == DLY_ONE) begin
          state_n      = ST_WAIT_FREE;
          drive_next_n = 1'b1;
        end else begin
          state_n = ST_DELAY;
        end
      end
      ST_WAIT_FREE: begin
        if (consume_s && move_s[DEPTH-1]) begin
          state_n      = LOAD_ST;
          cnt_n        = DLY_LOAD;
          drive_next_n = LOAD_PULSE;
        end else if (consume_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WAIT_FREE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output FSM state, delay counter and driveNext pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      drive_next_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      drive_next_r <= drive_next_n;
    end
  end

  // Stage occupancy, count, sticky error and the stage-0-vacated pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r  <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
      free_r  <= 1'b0;
    end else begin
      full_r  <= full_n;
      count_r <= count_n;
      err_r   <= err_r | drive_err_s | free_err_s;
      free_r  <= move_s[1];
    end
  end

  assign bus.o_fire      = rst ? '0 : move_s[DEPTH-1:0];
  assign bus.o_free      = free_r;
  assign bus.o_driveNext = drive_next_r;
  assign bus.o_count     = count_r;
  assign bus.o_err       = err_r;
endmodule

// File: tb/tb_cfifo_n.sv
// Scoreboard bench for cfifo_n: a token-slot reference model predicts fire/count/err each cycle
// and queues the cycles at which o_free / o_driveNext pulses are due; a monitor pops and compares.
module tb_cfifo_n;
`ifdef CFIFO_FLOWTHRU_EN
  localparam int D    = 2;
  localparam int OD   = 1;
  localparam bit FLOW = 1'b1;
`else
  localparam int D    = 4;
  localparam int OD   = 2;
  localparam bit FLOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  cfifo_n_if #(.DEPTH(D)) bus ();
  cfifo_n #(.DEPTH(D), .OUT_DELAY(OD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;
  int dn_q[$];
  int free_q[$];

  bit occ [D];
  int m_count  = 0;
  bit m_err    = 1'b0;
  int last_arr = -1000;

  bit pend = 1'b0;
  int dly  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string nm, input int act, input int exp);
    n_vec++;
    n_mis++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: tokens in slots; a token advances into an empty slot (or a vacating one in flow-through mode).
  always @(negedge clk) begin : ref_model
    bit adv [D+1];
    bit src;
    bit cons;
    int fire_exp;
    if (rst) begin
      chk("rst_fire", int'(bus.o_fire), 0);
      chk("rst_count", int'(bus.o_count), 0);
      chk("rst_err", int'(bus.o_err), 0);
      chk("rst_free", int'(bus.o_free), 0);
      chk("rst_drive_next", int'(bus.o_driveNext), 0);
      for (int k = 0; k < D; k++) occ[k] = 1'b0;
      m_count = 0;
      m_err   = 1'b0;
      dn_q.delete();
      free_q.delete();
    end else begin
      cons   = bus.i_freeNext && occ[D-1] && (cyc >= last_arr + OD);
      adv[D] = cons;
      fire_exp = 0;
      for (int k = D - 1; k >= 0; k--) begin
        src    = (k == 0) ? bus.i_drive : occ[(k > 0) ? k - 1 : 0];
        adv[k] = src && (!occ[k] || (FLOW && adv[k+1]));
        if (adv[k]) fire_exp |= (1 << k);
      end
      chk("fire", int'(bus.o_fire), fire_exp);
      chk("count", int'(bus.o_count), m_count);
      chk("err", int'(bus.o_err), int'(m_err));
      if (bus.i_drive && !adv[0]) m_err = 1'b1;
      if (bus.i_freeNext && !cons) m_err = 1'b1;
      m_count = m_count + int'(adv[0]) - int'(cons);
      for (int k = 0; k < D; k++) occ[k] = adv[k] || (occ[k] && !adv[k+1]);
      if (adv[D-1]) begin
        last_arr = cyc;
        dn_q.push_back(cyc + OD);
      end
      if (adv[1]) free_q.push_back(cyc + 1);
    end
  end

  // Monitor: every output pulse must match the head of its expectation queue.
  always @(negedge clk) begin : pulse_mon
    if (!rst) begin
      if (bus.o_driveNext) begin
        if (dn_q.size() == 0) report_fail("drive_next_unexpected", cyc, -1);
        else chk("drive_next_cycle", cyc, dn_q.pop_front());
      end else if (dn_q.size() > 0 && dn_q[0] <= cyc) begin
        report_fail("drive_next_missing", cyc, dn_q[0]);
        void'(dn_q.pop_front());
      end
      if (bus.o_free) begin
        if (free_q.size() == 0) report_fail("free_unexpected", cyc, -1);
        else chk("free_cycle", cyc, free_q.pop_front());
      end else if (free_q.size() > 0 && free_q[0] <= cyc) begin
        report_fail("free_missing", cyc, free_q[0]);
        void'(free_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_drive();
    bus.i_drive = 1'b1;
    tick();
    bus.i_drive = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_free(input string nm);
    int t = 0;
    while (!bus.o_free && t < 30) begin
      tick();
      t++;
    end
    if (!bus.o_free) report_fail(nm, 0, 1);
  endtask

  // Downstream consumer: answers each offer after 0..2 cycles.
  task automatic consumer_step();
    if (bus.o_driveNext) begin
      pend = 1'b1;
      dly  = $urandom_range(0, 2);
    end
    bus.i_freeNext = 1'b0;
    if (pend) begin
      if (dly == 0) begin
        bus.i_freeNext = 1'b1;
        pend = 1'b0;
      end else begin
        dly--;
      end
    end
  endtask

  initial begin
    bit may_drive;
    int n_tok;
    bus.i_drive    = 1'b0;
    bus.i_freeNext = 1'b0;

    for (int i = 0; i < 3; i++) begin
      bus.i_drive    = 1'($urandom_range(0, 1));
      bus.i_freeNext = 1'($urandom_range(0, 1));
      tick();
    end
    bus.i_drive    = 1'b0;
    bus.i_freeNext = 1'b0;
    rst = 1'b0;
    idle(20);

    pulse_drive();
    idle(D + OD);
    bus.i_freeNext = 1'b1;
    tick();
    bus.i_freeNext = 1'b0;
    chk("single_count", int'(bus.o_count), 0);
    chk("single_err", int'(bus.o_err), 0);
    idle(3);

    for (int i = 0; i < D; i++) begin
      pulse_drive();
      if (i < D - 1) wait_free("fill_free_timeout");
    end
    idle(D + OD + 2);
    chk("fill_count", int'(bus.o_count), D);
    bus.i_drive = 1'b1;
    #1;
    chk("fill_no_fire0", int'(bus.o_fire[0]), 0);
    tick();
    bus.i_drive = 1'b0;
    chk("fill_err", int'(bus.o_err), 1);
    chk("fill_count_hold", int'(bus.o_count), D);

    pulse_rst();
    bus.i_freeNext = 1'b1;
    tick();
    bus.i_freeNext = 1'b0;
    chk("spurious_err", int'(bus.o_err), 1);
    chk("spurious_count", int'(bus.o_count), 0);
    idle(2);

    pulse_rst();
    n_tok = (D < 3) ? D : 3;
    for (int i = 0; i < n_tok; i++) begin
      pulse_drive();
      if (i < n_tok - 1) wait_free("midop_free_timeout");
    end
    chk("midop_count_before", int'(bus.o_count), n_tok);
    pulse_rst();
    chk("midop_count_after", int'(bus.o_count), 0);
    chk("midop_err_after", int'(bus.o_err), 0);
    idle(20);

    may_drive = 1'b1;
    for (int i = 0; i < 400; i++) begin
      consumer_step();
      if (bus.o_free) may_drive = 1'b1;
      bus.i_drive = 1'b0;
      if (may_drive && ($urandom_range(0, 1) == 1)) begin
        bus.i_drive = 1'b1;
        may_drive   = 1'b0;
      end
      tick();
    end
    bus.i_drive = 1'b0;
    for (int i = 0; i < 60; i++) begin
      consumer_step();
      tick();
    end
    bus.i_freeNext = 1'b0;
    chk("drain_count", int'(bus.o_count), 0);
    chk("random_err", int'(bus.o_err), 0);

    pulse_rst();
    pend = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.i_drive    = 1'b1;
      bus.i_freeNext = bus.o_driveNext;
      tick();
    end
    bus.i_drive = 1'b0;
    chk("stream_err", int'(bus.o_err), FLOW ? 0 : 1);
    for (int i = 0; i < 40; i++) begin
      bus.i_freeNext = bus.o_driveNext;
      tick();
    end
    bus.i_freeNext = 1'b0;
    idle(2);
    chk("final_count", int'(bus.o_count), 0);
    chk("final_dn_q_empty", dn_q.size(), 0);
    chk("final_free_q_empty", free_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
